// File: rtl/b_preadd_stage.sv
// ---------------------------------------------------------------------------
// b_preadd_stage
// Registered B-port front end of a DSP slice: optional D/B/OPMODE input
// registers, an 18-bit pre-adder/subtracter (D +/- B), an operand select
// between the pre-adder result and B, and an optional stage-2 (B1) register
// feeding the multiplier and the cascade output. A valid bit follows the B
// path so neighbouring stages can track latency.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset of every register
//   CED        enable for the D register
//   CEB        enable for B0, B1 and both valid stages
//   CEOPMODE   enable for the OPMODE register
//   D, B       pre-adder operand / B operand (WIDTH bits)
//   OPMODE6    0 = D+B, 1 = D-B
//   OPMODE4    0 = pass B0, 1 = pass pre-adder result
//   valid_in   qualifies B in the current cycle
//   B1_out     stage-2 operand
//   BCOUT      cascade output, identical to B1_out
//   valid_out  valid_in delayed by B0REG+B1REG enabled cycles
//
// A REG parameter of 0 makes that stage transparent; its register still
// exists but is never selected onto the datapath.
// ---------------------------------------------------------------------------
module b_preadd_stage #(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned DREG      = 1,
    parameter int unsigned B0REG     = 1,
    parameter int unsigned B1REG     = 1,
    parameter int unsigned OPMODEREG = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CED,
    input  logic             CEB,
    input  logic             CEOPMODE,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] B,
    input  logic             OPMODE6,
    input  logic             OPMODE4,
    input  logic             valid_in,
    output logic [WIDTH-1:0] B1_out,
    output logic [WIDTH-1:0] BCOUT,
    output logic             valid_out
);

    localparam int unsigned OP_W = 2;

    // Stage-1 registers
    logic [WIDTH-1:0] d_q,  d_d;
    logic [WIDTH-1:0] b0_q, b0_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             v1_q, v1_d;

    // Stage-2 registers
    logic [WIDTH-1:0] b1_q, b1_d;
    logic             v2_q, v2_d;

    // Stage-1 outputs after the register/bypass choice
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] b0_s;
    logic [OP_W-1:0]  op_s;
    logic             v1_s;

    // Pre-adder and operand select
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sel;

    // Next-state for every register: load when enabled, otherwise hold.
    always_comb begin
        d_d  = d_q;
        b0_d = b0_q;
        op_d = op_q;
        v1_d = v1_q;
        b1_d = b1_q;
        v2_d = v2_q;
        if (CED) begin
            d_d = D;
        end
        if (CEOPMODE) begin
            op_d = {OPMODE6, OPMODE4};
        end
        if (CEB) begin
            b0_d = B;
            v1_d = valid_in;
            b1_d = sel;
            v2_d = v1_s;
        end
    end

    // All state registers; reset overrides every enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_q  <= '0;
            b0_q <= '0;
            op_q <= '0;
            v1_q <= 1'b0;
            b1_q <= '0;
            v2_q <= 1'b0;
        end else begin
            d_q  <= d_d;
            b0_q <= b0_d;
            op_q <= op_d;
            v1_q <= v1_d;
            b1_q <= b1_d;
            v2_q <= v2_d;
        end
    end

    // Stage-1 register/bypass selection.
    always_comb begin
        d_s  = (DREG      != 0) ? d_q  : D;
        b0_s = (B0REG     != 0) ? b0_q : B;
        op_s = (OPMODEREG != 0) ? op_q : {OPMODE6, OPMODE4};
        v1_s = (B0REG     != 0) ? v1_q : valid_in;
    end

    // Pre-adder: modulo 2^WIDTH, carry/borrow dropped. op_s[1] = OPMODE6.
    always_comb begin
        if (op_s[1]) begin
            sum = WIDTH'(d_s - b0_s);
        end else begin
            sum = WIDTH'(d_s + b0_s);
        end
    end

    // Operand select: op_s[0] = OPMODE4.
    always_comb begin
        sel = op_s[0] ? sum : b0_s;
    end

    // Stage-2 register/bypass selection and cascade copy.
    always_comb begin
        B1_out    = (B1REG != 0) ? b1_q : sel;
        BCOUT     = B1_out;
        valid_out = (B1REG != 0) ? v2_q : v1_s;
    end

endmodule

// File: doc/b_preadd_stage.md
# b_preadd_stage

Registered B-port front end for the DSP48A1 slice. It optionally registers D and B (stage 1) and forms the 18-bit pre-adder/subtracter result D±B. It then selects either that result or the registered B operand under OPMODE[4], and optionally registers the selection (stage 2, B1). The B1 output drives the multiplier input, BCOUT, and the downstream 2:1 operand mux that builds the D:A:B concatenation for the post-adder X path. A valid bit travels alongside the B operand so benches and neighbouring stages can track latency.

## Interface
Parameters:
- WIDTH, 18, operand width of D, B, and all internal/output data.
- DREG, 1, 1 = D passes through a CED-enabled register; 0 = D is combinational.
- B0REG, 1, 1 = B passes through a CEB-enabled register; 0 = B is combinational.
- B1REG, 1, 1 = the selected operand passes through a CEB-enabled register; 0 = combinational.
- OPMODEREG, 1, 1 = OPMODE6/OPMODE4 pass through a CEOPMODE-enabled register; 0 = combinational.

Ports:
- CLK  in  1  single clock; all registers are rising-edge.
- RST  in  1  asynchronous, active-high reset of every register in the block.
- CED  in  1  clock enable for the D register.
- CEB  in  1  clock enable for the B0 register, the B1 register and both valid stages.
- CEOPMODE  in  1  clock enable for the OPMODE register.
- D  in  WIDTH  pre-adder operand.
- B  in  WIDTH  B operand.
- OPMODE6  in  1  0 = add (D+B), 1 = subtract (D−B).
- OPMODE4  in  1  0 = pass B0 to the B1 stage, 1 = pass the pre-adder result.
- valid_in  in  1  qualifies B in the current cycle.
- B1_out  out  WIDTH  stage-2 operand to the multiplier and the concatenation mux.
- BCOUT  out  WIDTH  cascade output; always identical to B1_out.
- valid_out  out  1  valid_in delayed by B0REG+B1REG enabled cycles.

## Operation
- Stage 1:
  - D_s = DREG ? D_r : D; D_r loads D when CED=1.
  - B0_s = B0REG ? B0_r : B; B0_r loads B when CEB=1.
  - op_s = OPMODEREG ? op_r : {OPMODE6, OPMODE4}; op_r loads when CEOPMODE=1.
- Pre-adder: sum = OPMODE6_s ? D_s − B0_s : D_s + B0_s.
  - Arithmetic is unsigned, modulo 2^WIDTH.
  - Carry and borrow are discarded; there is no overflow flag.
- Select: sel = OPMODE4_s ? sum : B0_s.
- Stage 2: B1_out = B1REG ? B1_r : sel; B1_r loads sel when CEB=1. BCOUT = B1_out.
- Valid pipeline:
  - v1 = B0REG ? v1_r : valid_in; v1_r loads valid_in when CEB=1.
  - valid_out = B1REG ? v2_r : v1; v2_r loads v1 when CEB=1.
- The valid bit tracks the B path only. If DREG≠B0REG, D is misaligned with B by one cycle. This is legal and is the user's responsibility.
- CE low holds the corresponding register's value. Data and valid are held together, so no valid token is lost or duplicated.
- Reset:
  - RST=1 forces D_r, B0_r, op_r, B1_r, v1_r and v2_r to 0 immediately, independent of CLK and all CEs.
  - RST has priority over every CE.
  - With all REG parameters = 1: B1_out = BCOUT = 0 and valid_out = 0 while RST is high and until the first enabled load after release.
  - With any REG parameter = 0, the affected outputs follow their combinational inputs regardless of RST.
- Reset mid-operation discards all in-flight operands and valid tokens. After release, the pipeline refills from fresh inputs; the pre-reset state is never output.

## Timing
- Latency from D/B to B1_out is B0REG+B1REG CEB-enabled cycles (0, 1 or 2).
- The OPMODE change takes effect on the same stage-1 boundary as B0 when OPMODEREG=B0REG=1.
- With all registers = 0, the block is purely combinational. Outputs settle in the same cycle; there are no registered paths.
- There are no backpressure or ready signals; CEB is the only stall mechanism.
- Simultaneous CEB=1 with an OPMODE4/OPMODE6 change: stage 2 captures the selection computed from the current stage-1 contents, so the new mode affects the next operand.

## Test plan
- Reset: all REG=1, assert RST for 3 cycles with D=B=0x3FFFF, valid_in=1. Required: B1_out = BCOUT = 0 and valid_out = 0 throughout, and still 0 in the first cycle after release.
- Add path: all REG=1, CEs=1, OPMODE={6:0, 4:1}, D=100, B=23, valid_in=1 for one cycle. Required: B1_out=123 and valid_out=1 exactly 2 cycles later, then valid_out=0.
- Subtract with wrap:
  - D=5, B=7, OPMODE6=1, OPMODE4=1. Required: B1_out=0x3FFFE after 2 cycles.
  - D=0x3FFFF, B=1, add. Required: B1_out=0x00000 after 2 cycles.
- Bypass: OPMODE4=0, D=500, B=0x0ABCD. Required: B1_out = BCOUT = 0x0ABCD after 2 cycles, independent of D and OPMODE6.
- Stall and reset mid-flight:
  - Stream B=1,2,3 with valid; drop CEB for 4 cycles after the second sample. Required: outputs hold with no duplication, and after CEB returns the sequence resumes 1,2,3.
  - Repeat with RST pulsed mid-stream. Required: outputs = 0 immediately; no pre-reset sample appears afterward.
- Combinational config: all REG=0, D=10, B=4, OPMODE6=1, OPMODE4=1. Required: B1_out=6 and valid_out = valid_in in the same cycle.
